// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Frequency-sweep sequencer for a DDS waveform generator.
//               Steps f_word from a start value by a fixed increment, holding
//               each point for a dwell time. Supports single-shot, sawtooth
//               and triangle sweeps. Parks the DDS at midscale when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
  parameter int FW_W  = 32,
  parameter int PW_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FW_W-1:0]  cfg_f_start,
  input  logic [FW_W-1:0]  cfg_f_step,
  input  logic [CNT_W-1:0] cfg_n_steps,
  input  logic [CNT_W-1:0] cfg_dwell,
  input  logic [1:0]       cfg_mode,
  input  logic [1:0]       cfg_wave,
  input  logic [PW_W-1:0]  cfg_phase,
  output logic [FW_W-1:0]  f_word,
  output logic [PW_W-1:0]  p_word,
  output logic [1:0]       model_sel,
  output logic             busy,
  output logic             step_tick,
  output logic             done,
  output logic [CNT_W-1:0] point_idx
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       MODE_SAW  = 2'd1;
  localparam logic [1:0]       MODE_TRI  = 2'd2;
  localparam logic [1:0]       WAVE_PARK = 2'd3;

  state_t           state_q;
  logic [FW_W-1:0]  f_word_q;
  logic [PW_W-1:0]  p_word_q;
  logic [1:0]       model_sel_q;
  logic             busy_q;
  logic             step_tick_q;
  logic             done_q;
  logic [CNT_W-1:0] point_idx_q;
  logic             dir_dn_q;
  logic [CNT_W-1:0] dwell_cnt_q;

  // Shadow copy of the configuration, frozen for the whole sweep
  logic [FW_W-1:0]  f_start_q;
  logic [FW_W-1:0]  f_step_q;
  logic [CNT_W-1:0] n_steps_q;
  logic [CNT_W-1:0] dwell_q;
  logic [1:0]       mode_q;

  // Candidate next frequency words and the effective dwell (0 counts as 1)
  logic [FW_W-1:0]  f_up_d;
  logic [FW_W-1:0]  f_dn_d;
  logic [CNT_W-1:0] dwell_d;

  assign f_up_d  = f_word_q + f_step_q;
  assign f_dn_d  = f_word_q - f_step_q;
  assign dwell_d = (cfg_dwell == CNT_ZERO) ? CNT_ONE : cfg_dwell;

  // Sweep FSM: all outputs registered; reset and abort force parked idle values
  always_ff @(posedge clk) begin
    step_tick_q <= 1'b0;
    done_q      <= 1'b0;
    if (reset || abort) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      f_word_q    <= '0;
      p_word_q    <= '0;
      model_sel_q <= WAVE_PARK;
      point_idx_q <= '0;
      dir_dn_q    <= 1'b0;
      dwell_cnt_q <= '0;
      if (reset) begin
        f_start_q <= '0;
        f_step_q  <= '0;
        n_steps_q <= '0;
        dwell_q   <= '0;
        mode_q    <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            f_word_q    <= cfg_f_start;
            p_word_q    <= cfg_phase;
            model_sel_q <= cfg_wave;
            point_idx_q <= '0;
            dir_dn_q    <= 1'b0;
            step_tick_q <= 1'b1;
            dwell_cnt_q <= dwell_d;
            f_start_q   <= cfg_f_start;
            f_step_q    <= cfg_f_step;
            n_steps_q   <= cfg_n_steps;
            dwell_q     <= dwell_d;
            mode_q      <= cfg_mode;
          end
        end
        S_RUN: begin
          if (dwell_cnt_q > CNT_ONE) begin
            dwell_cnt_q <= dwell_cnt_q - CNT_ONE;
          end else begin
            dwell_cnt_q <= dwell_q;
            if (!dir_dn_q && (point_idx_q < n_steps_q)) begin
              f_word_q    <= f_up_d;
              point_idx_q <= point_idx_q + CNT_ONE;
              step_tick_q <= 1'b1;
            end else if (dir_dn_q && (point_idx_q != CNT_ZERO)) begin
              f_word_q    <= f_dn_d;
              point_idx_q <= point_idx_q - CNT_ONE;
              step_tick_q <= 1'b1;
            end else if (mode_q == MODE_SAW) begin
              // Restart from the first point; a single-point sweep just holds
              f_word_q    <= f_start_q;
              point_idx_q <= '0;
              step_tick_q <= (n_steps_q != CNT_ZERO);
            end else if (mode_q == MODE_TRI) begin
              // Reverse and move on immediately so endpoints are not repeated
              if (n_steps_q != CNT_ZERO) begin
                step_tick_q <= 1'b1;
                if (dir_dn_q) begin
                  dir_dn_q    <= 1'b0;
                  f_word_q    <= f_up_d;
                  point_idx_q <= point_idx_q + CNT_ONE;
                end else begin
                  dir_dn_q    <= 1'b1;
                  f_word_q    <= f_dn_d;
                  point_idx_q <= point_idx_q - CNT_ONE;
                end
              end
            end else begin
              // Single-shot sweep finished: park and flag completion
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              f_word_q    <= '0;
              p_word_q    <= '0;
              model_sel_q <= WAVE_PARK;
              point_idx_q <= '0;
              dir_dn_q    <= 1'b0;
              dwell_cnt_q <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign f_word    = f_word_q;
  assign p_word    = p_word_q;
  assign model_sel = model_sel_q;
  assign busy      = busy_q;
  assign step_tick = step_tick_q;
  assign done      = done_q;
  assign point_idx = point_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_sweep_ctrl
// Description : Self-checking bench for dds_sweep_ctrl using an expected-value
//               queue filled per scenario and drained cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] cfg_f_start, cfg_f_step;
  logic [15:0] cfg_n_steps, cfg_dwell;
  logic [1:0]  cfg_mode, cfg_wave;
  logic [11:0] cfg_phase;
  logic [31:0] f_word;
  logic [11:0] p_word;
  logic [1:0]  model_sel;
  logic        busy, step_tick, done;
  logic [15:0] point_idx;

  typedef struct packed {
    logic        busy;
    logic [31:0] f;
    logic [11:0] p;
    logic [1:0]  ms;
    logic        tick;
    logic        done;
    logic [15:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t e, a;
  int   checks = 0;
  int   errors = 0;

  dds_sweep_ctrl #(.FW_W(32), .PW_W(12), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step),
    .cfg_n_steps(cfg_n_steps), .cfg_dwell(cfg_dwell),
    .cfg_mode(cfg_mode), .cfg_wave(cfg_wave), .cfg_phase(cfg_phase),
    .f_word(f_word), .p_word(p_word), .model_sel(model_sel),
    .busy(busy), .step_tick(step_tick), .done(done), .point_idx(point_idx)
  );

  always #5 clk = ~clk;

  function automatic exp_t idle_v(logic d);
    exp_t r;
    r.busy = 1'b0; r.f = 32'd0; r.p = 12'd0; r.ms = 2'd3;
    r.tick = 1'b0; r.done = d; r.idx = 16'd0;
    return r;
  endfunction

  function automatic exp_t run_v(logic [31:0] f, logic t, logic [15:0] idx,
                                 logic [1:0] w, logic [11:0] p);
    exp_t r;
    r.busy = 1'b1; r.f = f; r.p = p; r.ms = w;
    r.tick = t; r.done = 1'b0; r.idx = idx;
    return r;
  endfunction

  function automatic exp_t sample();
    exp_t r;
    r.busy = busy; r.f = f_word; r.p = p_word; r.ms = model_sel;
    r.tick = step_tick; r.done = done; r.idx = point_idx;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a config with a one-cycle start pulse; returns in cycle 1 of the sweep
  task automatic start_sweep(logic [31:0] fs, logic [31:0] st, logic [15:0] n,
                             logic [15:0] dw, logic [1:0] md, logic [1:0] wv,
                             logic [11:0] ph);
    cfg_f_start = fs; cfg_f_step = st; cfg_n_steps = n;
    cfg_dwell = dw; cfg_mode = md; cfg_wave = wv; cfg_phase = ph;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_f_start = '0; cfg_f_step = '0; cfg_n_steps = '0; cfg_dwell = '0;
    cfg_mode = '0; cfg_wave = '0; cfg_phase = '0;
    cycle(); cycle();
    sb.push_back(idle_v(1'b0));
    sb.push_back(idle_v(1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset[%0d]: actual=%h required=%h", i, a, e);
      end
      if (i == 0) reset = 1'b0;
      cycle();
    end
  endtask

  task automatic test_single();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++)
        sb.push_back(run_v(32'd100 + 32'(10 * k), c == 0, 16'(k), 2'd1, 12'h123));
    sb.push_back(idle_v(1'b1));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'd100, 32'd10, 16'd2, 16'd2, 2'd0, 2'd1, 12'h123);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL single[%0d]: actual=%h required=%h", i, a, e);
      end
      cycle();
    end
  endtask

  task automatic test_triangle();
    int idx_tab [7] = '{0, 1, 2, 1, 0, 1, 2};
    for (int k = 0; k < 7; k++)
      sb.push_back(run_v(32'd100 + 32'(10 * idx_tab[k]), 1'b1, 16'(idx_tab[k]),
                         2'd2, 12'hABC));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'd100, 32'd10, 16'd2, 16'd1, 2'd2, 2'd2, 12'hABC);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL triangle[%0d]: actual=%h required=%h", i, a, e);
      end
      if (i == 6) abort = 1'b1;
      cycle();
      abort = 1'b0;
    end
  endtask

  task automatic test_sawtooth_wrap();
    for (int k = 0; k < 9; k++)
      sb.push_back(run_v(((k / 3) == 1) ? 32'h0000_0000 : 32'hFFFF_FFF0,
                         (k % 3) == 0, 16'((k / 3) % 2), 2'd0, 12'h055));
    sb.push_back(idle_v(1'b0));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'hFFFF_FFF0, 32'h10, 16'd1, 16'd3, 2'd1, 2'd0, 12'h055);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sawtooth[%0d]: actual=%h required=%h", i, a, e);
      end
      if (i == 8) abort = 1'b1;
      cycle();
      abort = 1'b0;
    end
  endtask

  task automatic test_dwell0_n0();
    sb.push_back(run_v(32'd42, 1'b1, 16'd0, 2'd1, 12'h001));
    sb.push_back(idle_v(1'b1));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'd42, 32'd7, 16'd0, 16'd0, 2'd0, 2'd1, 12'h001);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dwell0_n0[%0d]: actual=%h required=%h", i, a, e);
      end
      cycle();
    end
  endtask

  task automatic test_tri_single_point();
    sb.push_back(run_v(32'd900, 1'b1, 16'd0, 2'd2, 12'h200));
    for (int k = 0; k < 4; k++)
      sb.push_back(run_v(32'd900, 1'b0, 16'd0, 2'd2, 12'h200));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'd900, 32'd50, 16'd0, 16'd1, 2'd2, 2'd2, 12'h200);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL tri_n0[%0d]: actual=%h required=%h", i, a, e);
      end
      if (i == 4) abort = 1'b1;
      cycle();
      abort = 1'b0;
    end
  endtask

  task automatic test_abort_mid();
    for (int c = 0; c < 3; c++)
      sb.push_back(run_v(32'd1000, c == 0, 16'd0, 2'd1, 12'h321));
    sb.push_back(run_v(32'd1025, 1'b1, 16'd1, 2'd1, 12'h321));
    sb.push_back(idle_v(1'b0));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'd1000, 32'd25, 16'd3, 16'd3, 2'd0, 2'd1, 12'h321);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL abort_mid[%0d]: actual=%h required=%h", i, a, e);
      end
      if (i == 3) abort = 1'b1;
      cycle();
      abort = 1'b0;
    end
  endtask

  task automatic test_start_while_busy();
    sb.push_back(run_v(32'd500, 1'b1, 16'd0, 2'd0, 12'h0F0));
    sb.push_back(run_v(32'd500, 1'b0, 16'd0, 2'd0, 12'h0F0));
    sb.push_back(run_v(32'd505, 1'b1, 16'd1, 2'd0, 12'h0F0));
    sb.push_back(run_v(32'd505, 1'b0, 16'd1, 2'd0, 12'h0F0));
    sb.push_back(idle_v(1'b1));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'd500, 32'd5, 16'd1, 16'd2, 2'd0, 2'd0, 12'h0F0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL start_busy[%0d]: actual=%h required=%h", i, a, e);
      end
      if (i == 1) begin
        cfg_f_start = 32'd9999; cfg_f_step = 32'd1; cfg_n_steps = 16'd9;
        cfg_dwell = 16'd5; cfg_mode = 2'd1; cfg_wave = 2'd3; cfg_phase = 12'hFFF;
        start = 1'b1;
      end
      cycle();
      start = 1'b0;
    end
  endtask

  task automatic test_start_abort_idle();
    cfg_f_start = 32'd77; cfg_f_step = 32'd1; cfg_n_steps = 16'd1;
    cfg_dwell = 16'd1; cfg_mode = 2'd0; cfg_wave = 2'd1; cfg_phase = 12'h111;
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    sb.push_back(idle_v(1'b0));
    sb.push_back(idle_v(1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL start_abort[%0d]: actual=%h required=%h", i, a, e);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    sb.push_back(run_v(32'd2000, 1'b1, 16'd0, 2'd2, 12'h444));
    sb.push_back(run_v(32'd2001, 1'b1, 16'd1, 2'd2, 12'h444));
    sb.push_back(idle_v(1'b0));
    start_sweep(32'd2000, 32'd1, 16'd2, 16'd1, 2'd1, 2'd2, 12'h444);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d]: actual=%h required=%h", i, a, e);
      end
      if (i == 1) reset = 1'b1;
      cycle();
      reset = 1'b0;
    end
    sb.push_back(run_v(32'd7, 1'b1, 16'd0, 2'd1, 12'h010));
    sb.push_back(run_v(32'd10, 1'b1, 16'd1, 2'd1, 12'h010));
    sb.push_back(idle_v(1'b1));
    start_sweep(32'd7, 32'd3, 16'd1, 16'd1, 2'd3, 2'd1, 12'h010);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL restart[%0d]: actual=%h required=%h", i, a, e);
      end
      cycle();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_triangle();
    test_sawtooth_wrap();
    test_dwell0_n0();
    test_tri_single_point();
    test_abort_mid();
    test_start_while_busy();
    test_start_abort_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the control inputs of the DDS waveform generator: f_word, p_word and model_sel.
- On a start pulse it captures a sweep configuration.
- It then steps the frequency control word from a start value by a fixed increment, holding each point for a programmable dwell time.
- Sweep shapes: single-shot, sawtooth-repeat and triangle-repeat.
- When idle it parks the DDS at midscale, using model_sel = 3.

Parameters:
FW_W, 32, frequency word / step width
PW_W, 12, phase word width
CNT_W, 16, width of step count, dwell count and point index

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin sweep; ignored while busy
abort  input  1  terminates sweep; priority over start and all sweep activity
cfg_f_start  input  FW_W  first frequency word
cfg_f_step  input  FW_W  increment per point (unsigned)
cfg_n_steps  input  CNT_W  number of increments; sweep has n_steps+1 points
cfg_dwell  input  CNT_W  cycles per point; 0 treated as 1
cfg_mode  input  2  0 single, 1 sawtooth repeat, 2 triangle repeat, 3 treated as 0
cfg_wave  input  2  model_sel value driven during sweep
cfg_phase  input  PW_W  p_word value driven during sweep
f_word  output  FW_W  frequency control word to DDS
p_word  output  PW_W  phase control word to DDS
model_sel  output  2  waveform select to DDS
busy  output  1  sweep in progress
step_tick  output  1  one-cycle pulse in first cycle of every new point
done  output  1  one-cycle pulse when single sweep completes
point_idx  output  CNT_W  index of current point, 0..n_steps

Behaviour:
- All outputs are registered.
- Reset values: f_word=0, p_word=0, model_sel=3, busy=0, step_tick=0, done=0, point_idx=0, FSM=IDLE.
- FSM states: IDLE, RUN.
- Config is captured into shadow registers on the accepted start edge. Input changes during a sweep have no effect.

IDLE:
- Outputs hold reset values, except done, which may pulse for the single cycle after a completion.
- start=1 and abort=0 sampled at edge k → at edge k:
  - busy=1, f_word=cfg_f_start, p_word=cfg_phase, model_sel=cfg_wave, point_idx=0, step_tick=1, dir=up.
  - dwell counter loaded with D=max(cfg_dwell,1).
  - Latency: new outputs are visible in the cycle following the start cycle.

RUN:
- Each point is held exactly D cycles. On the last dwell cycle the next edge advances:
  - point_idx<n_steps, dir up: f_word+=f_step (modulo 2^FW_W, no saturation), point_idx+1.
  - point_idx>0, dir down: f_word-=f_step (modulo), point_idx-1.
  - Endpoint reached (idx==n_steps going up, or idx==0 going down):
    - Mode 0/3: → IDLE; done=1 for one cycle; busy=0, f_word=0, p_word=0, model_sel=3 on the same edge.
    - Mode 1: f_word=f_start, point_idx=0.
    - Mode 2: direction reverses and the next point is computed immediately, so endpoints are not repeated.
  - step_tick=1 on every edge that loads a new point, except single-point repeat.
- n_steps=0:
  - Mode 0: one point of D cycles, then done.
  - Modes 1/2: f_start is held until abort, with no step_tick after the first.
- Mode 2 with n_steps=0 does not reverse or step.

abort:
- abort=1 at any edge → IDLE values at that edge.
- done is not asserted.
- abort together with start in IDLE: stays IDLE.

Other rules:
- start while busy: ignored, no config capture.
- reset mid-sweep: reset values at the next edge, with priority over abort/start.

Test Plan:
- Single sweep: start in cycle 0, f_start=100, step=10, n=2, dwell=2, mode 0 → f_word is 100 in cycles 1-2, 110 in 3-4, 120 in 5-6. Cycle 7: done=1, busy=0, f_word=0, model_sel=3. step_tick in cycles 1, 3, 5.
- Triangle: f_start=100, step=10, n=2, dwell=1, mode 2 → f_word sequence 100,110,120,110,100,110,... with no repeated endpoints, and point_idx 0,1,2,1,0,1.
- Sawtooth + wrap: f_start=0xFFFFFFF0, step=0x10, n=1, dwell=3, mode 1 → 0xFFFFFFF0 ×3, 0x00000000 ×3, 0xFFFFFFF0 ×3, ...; done never asserted.
- Dwell 0 and n 0: dwell=0, n=0, mode 0 → exactly one cycle at f_start, then done pulse.
- Abort/start interactions:
  - abort in the middle of point 1 → IDLE values next cycle, no done.
  - start re-issued while busy → sweep continues unchanged.
  - start+abort together in IDLE → busy stays 0.
- Reset mid-sweep in mode 1 → all outputs at reset values next cycle; a new start afterwards runs cleanly from point 0.
